// File: rtl/ff_exc_driver.sv
// ff_exc_driver: steps an external W-bit bank of D/T/JK/SR flip-flops through
// a stream of target states. It keeps its own model of the bank contents,
// drives the excitation for each transition, then reads the bank back and
// counts mismatches.
module ff_exc_driver #(
  parameter int W  = 4,
  parameter int CW = 8
) (
  input  logic          ck,
  input  logic          cl,
  input  logic [1:0]    ftype,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  input  logic [W-1:0]  q_fb,
  output logic [W-1:0]  exc_a,
  output logic [W-1:0]  exc_b,
  output logic          chk_done,
  output logic          chk_err,
  output logic [CW-1:0] err_cnt,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [1:0] TYPE_D = 2'b00;
  localparam logic [1:0] TYPE_T = 2'b01;

  state_t          state_reg, state_next;
  logic [W-1:0]    cur_reg;       // model of what the bank holds
  logic [W-1:0]    tgt_reg;       // target of the transaction in flight
  logic [1:0]      typ_reg;       // bank type latched at accept
  logic            chk_done_reg;
  logic            chk_err_reg;
  logic [CW-1:0]   err_cnt_reg;
  logic [W-1:0]    q_goal;        // state the bank should hold after this edge

  // State register.
  always_ff @(posedge ck or negedge cl) begin
    if (!cl) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and handshake/status decode; depends on registered state only
  // except for the in_valid branch condition.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = APPLY;
      end
      APPLY:   state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction datapath: latch target at accept, advance the model after
  // APPLY, and score the readback at the end of CHECK.
  always_ff @(posedge ck or negedge cl) begin
    if (!cl) begin
      cur_reg      <= '0;
      tgt_reg      <= '0;
      typ_reg      <= TYPE_D;
      chk_done_reg <= 1'b0;
      chk_err_reg  <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      chk_done_reg <= (state_reg == CHECK);
      chk_err_reg  <= (state_reg == CHECK) && (q_fb != tgt_reg);
      if (state_reg == IDLE && in_valid) begin
        tgt_reg <= in_data;
        typ_reg <= ftype;
      end
      // The model advances unconditionally; a bad readback never resyncs it.
      if (state_reg == APPLY) cur_reg <= tgt_reg;
      if (state_reg == CHECK && q_fb != tgt_reg && err_cnt_reg != {CW{1'b1}})
        err_cnt_reg <= err_cnt_reg + CW'(1);
    end
  end

  // Outside APPLY the goal is the current state, which turns the transition
  // excitation into the hold excitation (d=cur, t/j/k/s/r=0).
  assign q_goal = (state_reg == APPLY) ? tgt_reg : cur_reg;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_exc
      // Per-bit excitation for cur[gi] -> q_goal[gi], don't-cares as 0.
      always_comb begin
        exc_a[gi] = 1'b0;
        exc_b[gi] = 1'b0;
        case (typ_reg)
          TYPE_D: exc_a[gi] = q_goal[gi];
          TYPE_T: exc_a[gi] = cur_reg[gi] ^ q_goal[gi];
          default: begin
            // JK and SR share the same minimal excitation; set and reset
            // are never asserted together.
            exc_a[gi] = ~cur_reg[gi] & q_goal[gi];
            exc_b[gi] = cur_reg[gi] & ~q_goal[gi];
          end
        endcase
      end
    end
  endgenerate

  assign chk_done = chk_done_reg;
  assign chk_err  = chk_err_reg;
  assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_ff_exc_driver.sv
// Testbench for ff_exc_driver: a behavioural FF bank is driven by the DUT and
// each transaction is checked against a transaction-level model.
module tb_ff_exc_driver;
  localparam int W  = 4;
  localparam int CW = 2;

  logic          ck = 1'b0;
  logic          cl = 1'b0;
  logic [1:0]    ftype = 2'b00;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic [W-1:0]  q_fb;
  logic [W-1:0]  exc_a, exc_b;
  logic          chk_done, chk_err;
  logic [CW-1:0] err_cnt;
  logic          busy;

  int tests = 0;
  int fails = 0;

  // Transaction-level model
  logic [W-1:0] m_cur = '0;
  logic [1:0]   m_typ = 2'b00;
  int           m_err = 0;

  // Behavioural bank
  logic [W-1:0] bank_q;
  logic [1:0]   bank_type = 2'b00;
  bit           stuck = 1'b0;

  ff_exc_driver #(.W(W), .CW(CW)) dut (
    .ck(ck), .cl(cl), .ftype(ftype), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .q_fb(q_fb), .exc_a(exc_a), .exc_b(exc_b),
    .chk_done(chk_done), .chk_err(chk_err), .err_cnt(err_cnt), .busy(busy)
  );

  always #5 ck = ~ck;

  // Bank of flip-flops of the selected type, sharing clock and clear.
  always @(posedge ck or negedge cl) begin
    if (!cl) bank_q <= '0;
    else case (bank_type)
      2'b00: bank_q <= exc_a;
      2'b01: bank_q <= bank_q ^ exc_a;
      2'b10: bank_q <= (exc_a & ~bank_q) | (~exc_b & bank_q);
      default: bank_q <= exc_a | (bank_q & ~exc_b);
    endcase
  end

  assign q_fb = stuck ? '0 : bank_q;

  // Expected {exc_b, exc_a} to move a bank of type ft from q to qn.
  function automatic logic [2*W-1:0] exc_model(input logic [1:0] ft,
                                               input logic [W-1:0] q,
                                               input logic [W-1:0] qn);
    logic [W-1:0] a, b;
    a = '0; b = '0;
    for (int i = 0; i < W; i++) begin
      if (ft == 2'b00) a[i] = qn[i];
      else if (ft == 2'b01) a[i] = (q[i] != qn[i]);
      else begin
        if (!q[i] && qn[i]) a[i] = 1'b1;   // must set
        if (q[i] && !qn[i]) b[i] = 1'b1;   // must clear
      end
    end
    return {b, a};
  endfunction

  // One full transaction from IDLE, checking every cycle.
  task automatic do_txn(input logic [1:0] ft, input logic [W-1:0] tg, input string nm);
    logic [2*W-1:0] e;
    logic exp_err;
    e = exc_model(m_typ, m_cur, m_cur);
    tests++;
    if ({in_ready, busy, exc_b, exc_a} !== {2'b10, e}) begin
      fails++;
      $display("FAIL %s idle rdy/busy/exc got %b%b %h_%h exp 10 %h", nm, in_ready, busy, exc_b, exc_a, e);
    end
    in_valid = 1'b1; ftype = ft; in_data = tg;
    @(posedge ck); #1;
    in_valid = 1'b0; in_data = W'($urandom); ftype = 2'($urandom);
    bank_type = ft; m_typ = ft;
    e = exc_model(ft, m_cur, tg);
    $display("[TB] %s type=%0d cur=%h tgt=%h exc_b/a=%h_%h", nm, ft, m_cur, tg, exc_b, exc_a);
    tests++;
    if ({in_ready, busy, exc_b, exc_a} !== {2'b01, e}) begin
      fails++;
      $display("FAIL %s apply rdy/busy/exc got %b%b %h_%h exp 01 %h", nm, in_ready, busy, exc_b, exc_a, e);
    end
    if (ft == 2'b11) begin
      tests++;
      if ((exc_a & exc_b) !== '0) begin
        fails++;
        $display("FAIL %s sr_overlap apply got %h exp 0", nm, exc_a & exc_b);
      end
    end
    @(posedge ck); #1;
    m_cur = tg;
    e = exc_model(ft, tg, tg);
    tests++;
    if ({in_ready, busy, chk_done, exc_b, exc_a} !== {3'b010, e}) begin
      fails++;
      $display("FAIL %s check rdy/busy/done/exc got %b%b%b %h_%h exp 010 %h", nm, in_ready, busy, chk_done, exc_b, exc_a, e);
    end
    @(posedge ck); #1;
    exp_err = stuck && (tg != '0);
    if (exp_err && m_err < 3) m_err++;
    tests++;
    if ({chk_done, chk_err, err_cnt} !== {1'b1, exp_err, CW'(m_err)}) begin
      fails++;
      $display("FAIL %s result done/err/cnt got %b%b %0d exp 1%b %0d", nm, chk_done, chk_err, err_cnt, exp_err, m_err);
    end
  endtask

  task automatic test_reset;
    cl = 1'b0;
    #3;
    tests++;
    if ({busy, in_ready, exc_a, exc_b, err_cnt, chk_done, chk_err} !== {2'b01, {(2*W+CW+2){1'b0}}}) begin
      fails++;
      $display("FAIL reset busy/rdy=%b%b exc=%h_%h cnt=%0d done/err=%b%b exp 01 0_0 0 00", busy, in_ready, exc_a, exc_b, err_cnt, chk_done, chk_err);
    end
    @(negedge ck); cl = 1'b1;
    @(posedge ck); #1;
    m_cur = '0; m_typ = 2'b00; m_err = 0; bank_type = 2'b00;
    $display("[TB] reset released");
  endtask

  task automatic test_d;
    do_txn(2'b00, 4'h5, "d1");
    do_txn(2'b00, 4'hA, "d2");
    do_txn(2'b00, 4'hA, "d3_same");
  endtask

  task automatic test_t;
    test_reset();
    do_txn(2'b01, 4'hF, "t1");
    do_txn(2'b01, 4'h9, "t2");
  endtask

  task automatic test_jk_sr;
    do_txn(2'b00, 4'h3, "jk_setup");
    do_txn(2'b10, 4'hC, "jk");
    do_txn(2'b00, 4'h3, "sr_setup");
    do_txn(2'b11, 4'hC, "sr");
  endtask

  task automatic test_random;
    for (int n = 0; n < 200; n++)
      do_txn(2'($urandom), W'($urandom), "rand");
  endtask

  task automatic test_stuck;
    stuck = 1'b1;
    do_txn(2'b00, 4'h1, "stuck1");
    do_txn(2'b00, 4'h2, "stuck2");
    do_txn(2'b00, 4'h3, "stuck3");
    do_txn(2'b00, 4'h4, "stuck_sat");
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid_apply;
    do_txn(2'b00, 4'hA, "pre_rst");
    in_valid = 1'b1; ftype = 2'b01; in_data = 4'h3;
    @(posedge ck); #1;
    in_valid = 1'b0; bank_type = 2'b01;
    cl = 1'b0;
    #1;
    tests++;
    if ({busy, in_ready, exc_a, exc_b, err_cnt, chk_done} !== {2'b01, {(2*W+CW+1){1'b0}}}) begin
      fails++;
      $display("FAIL mid_rst busy/rdy=%b%b exc=%h_%h cnt=%0d done=%b exp 01 0_0 0 0", busy, in_ready, exc_a, exc_b, err_cnt, chk_done);
    end
    @(negedge ck); cl = 1'b1;
    m_cur = '0; m_typ = 2'b00; m_err = 0; bank_type = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(posedge ck); #1;
      tests++;
      if ({chk_done, busy} !== 2'b00) begin
        fails++;
        $display("FAIL mid_rst_quiet cycle %0d done/busy got %b%b exp 00", k, chk_done, busy);
      end
    end
    do_txn(2'b01, 4'h5, "post_rst");
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] t;
    t = W'($urandom);
    in_valid = 1'b1; ftype = 2'b00; in_data = t;
    for (int k = 0; k < 4; k++) begin
      @(posedge ck); #1;
      m_typ = 2'b00; bank_type = 2'b00;
      tests++;
      if ({in_ready, busy, exc_a} !== {2'b01, t}) begin
        fails++;
        $display("FAIL b2b_apply %0d rdy/busy/exc_a got %b%b %h exp 01 %h", k, in_ready, busy, exc_a, t);
      end
      in_data = W'($urandom); ftype = 2'($urandom);
      @(posedge ck); #1;
      m_cur = t;
      tests++;
      if ({in_ready, busy, exc_a} !== {2'b01, t}) begin
        fails++;
        $display("FAIL b2b_check %0d rdy/busy/exc_a got %b%b %h exp 01 %h", k, in_ready, busy, exc_a, t);
      end
      in_data = W'($urandom);
      @(posedge ck); #1;
      tests++;
      if ({chk_done, chk_err, in_ready, err_cnt} !== {3'b101, CW'(m_err)}) begin
        fails++;
        $display("FAIL b2b_done %0d done/err/rdy/cnt got %b%b%b %0d exp 101 %0d", k, chk_done, chk_err, in_ready, err_cnt, m_err);
      end
      $display("[TB] b2b %0d tgt=%h done=%b", k, t, chk_done);
      t = W'($urandom);
      in_data = t; ftype = 2'b00;
      if (k == 3) in_valid = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_d();
    test_t();
    test_jk_sr();
    test_random();
    test_stuck();
    test_reset_mid_apply();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
